// File: rtl/serializer_10b_if.sv
// Symbol handshake between the 8b/10b encoder and the serializer.
// Valid/ready: a symbol transfers on a rising clk edge where din_valid and
// din_ready are both high; the source holds din stable while din_valid is high
// and din_ready is low, and din is ignored while din_valid is low.
interface serializer_10b_if #(
    parameter int SYM_W = 10
);
    logic [SYM_W-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/serializer_10b.sv
// Transmit-side parallel-to-serial converter for the 8b/10b link.
// Shifts 10-bit symbols out LSB first, one bit per clk. A one-entry holding
// buffer keeps the line at full rate; when nothing is pending the IDLE_SYM
// comma is sent so the far end always sees a continuously framed stream.
module serializer_10b #(
    parameter int               SYM_W    = 10,
    parameter logic [SYM_W-1:0] IDLE_SYM = 10'h17C,
    parameter int               CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    serializer_10b_if.slave    sym_if,
    output logic               dout,
    output logic               frame_start,
    output logic               idle_active,
    output logic [CNT_W-1:0]   sym_count
);
    localparam int            BW   = $clog2(SYM_W);
    localparam logic [BW-1:0] LAST = BW'(SYM_W - 1);

    logic [SYM_W-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SYM_W-1:0] hold_reg_q, hold_reg_d;
    logic             hold_valid_q, hold_valid_d;
    logic             idle_q, idle_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic load;
    logic din_ready;
    logic accept;

    // Next-state: advance the bit counter, shift, and at the symbol boundary
    // pick held symbol, then bypassed input, then idle fill.
    always_comb begin
        load         = (bit_cnt_q == LAST);
        din_ready    = ~reset & (~hold_valid_q | load);
        accept       = sym_if.din_valid & din_ready;
        bit_cnt_d    = load ? '0 : bit_cnt_q + 1'b1;
        shift_d      = {1'b0, shift_q[SYM_W-1:1]};
        hold_reg_d   = hold_reg_q;
        hold_valid_d = hold_valid_q;
        idle_d       = idle_q;
        cnt_d        = cnt_q;
        if (load) begin
            if (hold_valid_q) begin
                shift_d      = hold_reg_q;
                idle_d       = 1'b0;
                cnt_d        = cnt_q + 1'b1;
                // A new symbol accepted on the same edge refills the buffer.
                hold_valid_d = accept;
                if (accept) begin
                    hold_reg_d = sym_if.din;
                end
            end else if (accept) begin
                shift_d = sym_if.din;
                idle_d  = 1'b0;
                cnt_d   = cnt_q + 1'b1;
            end else begin
                shift_d = IDLE_SYM;
                idle_d  = 1'b1;
            end
        end else if (accept) begin
            hold_reg_d   = sym_if.din;
            hold_valid_d = 1'b1;
        end
    end

    // State registers; reset drops partial and held symbols and restarts on idle bit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q      <= IDLE_SYM;
            bit_cnt_q    <= '0;
            hold_reg_q   <= '0;
            hold_valid_q <= 1'b0;
            idle_q       <= 1'b1;
            cnt_q        <= '0;
        end else begin
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            hold_reg_q   <= hold_reg_d;
            hold_valid_q <= hold_valid_d;
            idle_q       <= idle_d;
            cnt_q        <= cnt_d;
        end
    end

    assign sym_if.din_ready = din_ready;
    assign dout             = shift_q[0];
    assign frame_start      = (bit_cnt_q == '0);
    assign idle_active      = idle_q;
    assign sym_count        = cnt_q;
endmodule

// File: tb/tb_serializer_10b.sv
// Bench for serializer_10b: directed sequences followed by random traffic.
// Accepted symbols are queued by the driver; a negedge monitor acts as the
// far-end receiver, framing the line every SYM_W bits and comparing against
// the queue.
module tb_serializer_10b;
    localparam int               SYM_W = 10;
    localparam int               CNT_W = 16;
    localparam logic [SYM_W-1:0] IDLE  = 10'h17C;

    logic             clk = 1'b0;
    logic             reset;
    logic             dout;
    logic             frame_start;
    logic             idle_active;
    logic [CNT_W-1:0] sym_count;

    serializer_10b_if #(.SYM_W(SYM_W)) sif ();

    serializer_10b #(.SYM_W(SYM_W), .IDLE_SYM(IDLE), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .sym_if      (sif.slave),
        .dout        (dout),
        .frame_start (frame_start),
        .idle_active (idle_active),
        .sym_count   (sym_count)
    );

    // clock / reset sampling
    always #5 clk = ~clk;

    bit rst_at_edge = 1'b1;
    always @(posedge clk) rst_at_edge <= reset;

    // scoreboard state
    logic [SYM_W-1:0] exp_q[$];
    int               checks = 0;
    int               errors = 0;
    bit               last_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic step();
        @(negedge clk);
        last_acc = sif.din_valid & sif.din_ready;
        @(posedge clk);
        if (last_acc) exp_q.push_back(sif.din);
        #1;
    endtask

    task automatic send(input logic [SYM_W-1:0] w);
        int n = 0;
        sif.din_valid = 1'b1;
        sif.din       = w;
        do begin
            step();
            n++;
        end while (!last_acc && n < 40);
        chk("accept_timeout", 32'(last_acc), 32'd1);
    endtask

    // receiver model: line is framed every SYM_W bits; a frame carries the
    // oldest accepted-but-unsent symbol if there is one, otherwise idle fill.
    int               phase = 0;
    logic [SYM_W-1:0] cur_word = IDLE;
    bit               cur_idle = 1'b1;
    logic [CNT_W-1:0] model_cnt = '0;
    bit               exp_ready;

    always @(negedge clk) begin
        if (rst_at_edge) begin
            exp_q.delete();
            model_cnt = '0;
            phase     = 0;
            cur_word  = IDLE;
            cur_idle  = 1'b1;
            chk("reset_dout", 32'(dout), 32'd0);
            chk("reset_frame_start", 32'(frame_start), 32'd1);
            chk("reset_idle_active", 32'(idle_active), 32'd1);
            chk("reset_sym_count", 32'(sym_count), 32'd0);
        end else begin
            phase = (phase + 1) % SYM_W;
            chk("frame_start", 32'(frame_start), 32'(phase == 0));
            if (phase == 0) begin
                if (exp_q.size() > 0) begin
                    cur_word = exp_q.pop_front();
                    cur_idle = 1'b0;
                    model_cnt++;
                end else begin
                    cur_word = IDLE;
                    cur_idle = 1'b1;
                end
                chk("sym_count", 32'(sym_count), 32'(model_cnt));
            end
            chk("dout", 32'(dout), 32'(cur_word[phase]));
            chk("idle_active", 32'(idle_active), 32'(cur_idle));
        end
        exp_ready = reset ? 1'b0 : ((phase == SYM_W - 1) || (exp_q.size() == 0));
        chk("din_ready", 32'(sif.din_ready), 32'(exp_ready));
    end

    // stimulus sequence and final report
    initial begin
        reset         = 1'b1;
        sif.din_valid = 1'b0;
        sif.din       = '0;
        repeat (3) step();
        reset = 1'b0;

        // idle fill only
        repeat (30) step();

        // single symbol
        send(10'h2A5);
        sif.din_valid = 1'b0;
        repeat (25) step();

        // back-to-back with valid held high
        send(10'h001);
        send(10'h3FF);
        send(10'h155);
        sif.din_valid = 1'b0;
        repeat (40) step();

        // mid-symbol arrival, then reset while a symbol is held
        repeat (3) step();
        send(10'h0F0);
        send(10'h30C);
        sif.din_valid = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        repeat (25) step();

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            if (!sif.din_valid && $urandom_range(0, 2) == 0) begin
                sif.din_valid = 1'b1;
                sif.din       = SYM_W'($urandom);
            end
            step();
            if (last_acc) begin
                if ($urandom_range(0, 1) == 1) sif.din = SYM_W'($urandom);
                else sif.din_valid = 1'b0;
            end
        end
        sif.din_valid = 1'b0;
        repeat (30) step();
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
